// File: rtl/wb_commit_stage_pkg.sv
// Shared constants and bundle layout for the two-slot write-back commit stage.
package wb_commit_stage_pkg;

  localparam int unsigned NREG = 8;   // architectural registers, equals 2**AW
  localparam int unsigned AW   = 3;   // destination index width
  localparam int unsigned DW   = 32;  // data width

  // One VLIW bundle as latched by the stage: {we2, rd2, d2, we1, rd1, d1}.
  typedef struct packed {
    logic          we2;
    logic [AW-1:0] rd2;
    logic [DW-1:0] d2;
    logic          we1;
    logic [AW-1:0] rd1;
    logic [DW-1:0] d1;
  } bundle_t;

  localparam int unsigned BundleW = 2 * (1 + AW + DW);

  // Both slots write the same register; slot 2 wins.
  function automatic logic is_conflict(input bundle_t b);
    return b.we1 & b.we2 & (b.rd1 == b.rd2);
  endfunction

endpackage

// File: rtl/wb_rd_decoder.sv
// Destination index to one-hot register decode, all-zero when disabled.
module wb_rd_decoder #(
  parameter int unsigned AW   = 3,
  parameter int unsigned NREG = 8  // must equal 2**AW
) (
  input  logic            en_i,
  input  logic [AW-1:0]   idx_i,
  output logic [NREG-1:0] onehot_o
);

  // One-hot decode of idx_i gated by en_i.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Two-slot VLIW write-back commit stage: head + skid buffer in front of a
// 2-write-port register file, with slot-2-wins conflict resolution.
module wb_commit_stage
  import wb_commit_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            s1_we,
  input  logic [AW-1:0]   s1_rd,
  input  logic [DW-1:0]   s1_data,
  input  logic            s2_we,
  input  logic [AW-1:0]   s2_rd,
  input  logic [DW-1:0]   s2_data,
  input  logic            wb_hold,
  output logic            regWrite1,
  output logic            regWrite2,
  output logic [DW-1:0]   writeData_1,
  output logic [DW-1:0]   writeData_2,
  output logic [NREG-1:0] dec_out,
  output logic [NREG-1:0] wsel,
  output logic [7:0]      conflict_cnt
);

  bundle_t    head_q, head_d, skid_q, skid_d, in_bundle;
  logic       head_v_q, head_v_d, skid_v_q, skid_v_d;
  logic [7:0] cnt_q, cnt_d;
  logic       accept, drain, g;
  logic [NREG-1:0] dec1, dec2;

  assign in_bundle = '{we2: s2_we, rd2: s2_rd, d2: s2_data,
                       we1: s1_we, rd1: s1_rd, d1: s1_data};

  // Ready comes from a flop only, so wb_hold never reaches in_ready.
  assign in_ready = ~skid_v_q;
  assign accept   = in_valid & in_ready;
  assign drain    = head_v_q & ~wb_hold;
  assign g        = drain;

  // Next-state for head/skid occupancy and the conflict counter.
  always_comb begin
    head_d   = head_q;
    head_v_d = head_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    cnt_d    = cnt_q;

    if (drain || !head_v_q) begin
      if (skid_v_q) begin
        // in_ready is low whenever skid is full, so no input can arrive here.
        head_d   = skid_q;
        head_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept) begin
        head_d   = in_bundle;
        head_v_d = 1'b1;
      end else begin
        head_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = in_bundle;
      skid_v_d = 1'b1;
    end

    if (drain && is_conflict(head_q) && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State registers; reset drops any buffered bundle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      head_v_q <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      head_q   <= head_d;
      head_v_q <= head_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      cnt_q    <= cnt_d;
    end
  end

  wb_rd_decoder #(.AW(AW), .NREG(NREG)) u_dec1 (
    .en_i     (head_q.we1),
    .idx_i    (head_q.rd1),
    .onehot_o (dec1)
  );

  wb_rd_decoder #(.AW(AW), .NREG(NREG)) u_dec2 (
    .en_i     (head_q.we2),
    .idx_i    (head_q.rd2),
    .onehot_o (dec2)
  );

  // Register-file drive; wsel is left ungated since dec_out already masks writes.
  always_comb begin
    regWrite1    = g & head_q.we1;
    regWrite2    = g & head_q.we2;
    writeData_1  = head_q.d1;
    writeData_2  = head_q.d2;
    dec_out      = (dec1 | dec2) & {NREG{g}};
    wsel         = dec2;
    conflict_cnt = cnt_q;
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: directed scenarios plus random
// traffic against a queue-based model of the stage and the register file.
module tb_wb_commit_stage;
  import wb_commit_stage_pkg::*;

  typedef struct packed {
    logic        we1;
    logic [2:0]  rd1;
    logic [31:0] d1;
    logic        we2;
    logic [2:0]  rd2;
    logic [31:0] d2;
  } tb_bundle_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic        s1_we = 1'b0, s2_we = 1'b0;
  logic [2:0]  s1_rd = '0, s2_rd = '0;
  logic [31:0] s1_data = '0, s2_data = '0;
  logic        wb_hold = 1'b0;
  logic        regWrite1, regWrite2;
  logic [31:0] writeData_1, writeData_2;
  logic [7:0]  dec_out, wsel, conflict_cnt;

  wb_commit_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .s1_we(s1_we), .s1_rd(s1_rd), .s1_data(s1_data),
    .s2_we(s2_we), .s2_rd(s2_rd), .s2_data(s2_data),
    .wb_hold(wb_hold), .regWrite1(regWrite1), .regWrite2(regWrite2),
    .writeData_1(writeData_1), .writeData_2(writeData_2),
    .dec_out(dec_out), .wsel(wsel), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Register file as the stage sees it: samples on negedge.
  logic [31:0] rf_dut [8];
  initial for (int i = 0; i < 8; i++) rf_dut[i] = '0;
  always @(negedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (dec_out[i]) rf_dut[i] <= wsel[i] ? writeData_2 : writeData_1;
    end
  end

  // Reference model: FIFO of buffered bundles (capacity 2), RF and counter.
  tb_bundle_t  q[$];
  tb_bundle_t  last_head;
  logic [31:0] rf_model [8];
  int          cnt_model;
  int          n_cmp = 0, n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic tb_bundle_t mk(input logic we1, input logic [2:0] rd1,
                                    input logic [31:0] d1, input logic we2,
                                    input logic [2:0] rd2, input logic [31:0] d2);
    tb_bundle_t b;
    b.we1 = we1; b.rd1 = rd1; b.d1 = d1;
    b.we2 = we2; b.rd2 = rd2; b.d2 = d2;
    return b;
  endfunction

  function automatic tb_bundle_t rnd_bundle();
    return mk(1'($urandom), 3'($urandom), $urandom, 1'($urandom), 3'($urandom), $urandom);
  endfunction

  task automatic model_reset();
    q.delete();
    last_head = '0;
    cnt_model = 0;
  endtask

  // One cycle: drive after posedge, check outputs, advance the model.
  task automatic step(input logic v, input logic h, input tb_bundle_t b, output logic acc);
    tb_bundle_t  cur, f;
    logic        g;
    logic [7:0]  exp_dec, exp_wsel;
    @(posedge clk);
    #1;
    in_valid = v; wb_hold = h;
    s1_we = b.we1; s1_rd = b.rd1; s1_data = b.d1;
    s2_we = b.we2; s2_rd = b.rd2; s2_data = b.d2;
    #1;
    cur = (q.size() > 0) ? q[0] : last_head;
    g = (q.size() > 0) && !h;
    exp_wsel = cur.we2 ? (8'd1 << cur.rd2) : 8'd0;
    exp_dec  = g ? ((cur.we1 ? (8'd1 << cur.rd1) : 8'd0) | exp_wsel) : 8'd0;
    chk("in_ready", in_ready, (q.size() < 2));
    chk("regWrite1", regWrite1, g & cur.we1);
    chk("regWrite2", regWrite2, g & cur.we2);
    chk("writeData_1", writeData_1, cur.d1);
    chk("writeData_2", writeData_2, cur.d2);
    chk("dec_out", dec_out, exp_dec);
    chk("wsel", wsel, exp_wsel);
    chk("conflict_cnt", conflict_cnt, cnt_model);

    acc = v && (q.size() < 2);
    if (q.size() > 0) last_head = q[0];
    if (g) begin
      f = q.pop_front();
      if (f.we1) rf_model[f.rd1] = f.d1;
      if (f.we2) rf_model[f.rd2] = f.d2;
      if (f.we1 && f.we2 && f.rd1 == f.rd2 && cnt_model < 255) cnt_model++;
    end
    if (acc) q.push_back(b);
    if (q.size() > 0) last_head = q[0];
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, a);
  endtask

  task automatic chk_rf();
    for (int i = 0; i < 8; i++) chk($sformatf("rf%0d", i), rf_dut[i], rf_model[i]);
  endtask

  initial begin
    logic       acc;
    tb_bundle_t pend;
    logic       have_pend;

    for (int i = 0; i < 8; i++) rf_model[i] = '0;
    model_reset();

    // Reset state.
    #3;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rw1", regWrite1, 1'b0);
    chk("rst_rw2", regWrite2, 1'b0);
    chk("rst_dec", dec_out, 8'h00);
    chk("rst_wsel", wsel, 8'h00);
    chk("rst_cnt", conflict_cnt, 8'd0);
    #9 reset = 1'b0;

    // Dual write to R2 and R5.
    step(1'b1, 1'b0, mk(1'b1, 3'd2, 32'h11111111, 1'b1, 3'd5, 32'h22222222), acc);
    step(1'b0, 1'b0, '0, acc);
    chk("dual_dec", dec_out, 8'h24);
    chk("dual_wsel", wsel, 8'h20);
    idle(1);
    chk("dual_r2", rf_dut[2], 32'h11111111);
    chk("dual_r5", rf_dut[5], 32'h22222222);

    // Same-destination conflict on R3: slot 2 wins.
    step(1'b1, 1'b0, mk(1'b1, 3'd3, 32'hAAAA0000, 1'b1, 3'd3, 32'h0000BBBB), acc);
    step(1'b0, 1'b0, '0, acc);
    chk("conf_dec", dec_out, 8'h08);
    chk("conf_wsel", wsel, 8'h08);
    idle(1);
    chk("conf_r3", rf_dut[3], 32'h0000BBBB);
    chk("conf_cnt", conflict_cnt, 8'd1);

    // Idle bundle occupies one drain cycle and writes nothing.
    step(1'b1, 1'b0, mk(1'b0, 3'd1, 32'hDEADBEEF, 1'b0, 3'd1, 32'hCAFEF00D), acc);
    idle(2);
    chk_rf();

    // Backpressure: A to head, B to skid, C refused until hold releases.
    step(1'b1, 1'b1, mk(1'b1, 3'd0, 32'hA0A0A0A0, 1'b0, 3'd0, 32'h0), acc);
    step(1'b1, 1'b1, mk(1'b1, 3'd1, 32'hB1B1B1B1, 1'b1, 3'd4, 32'hB4B4B4B4), acc);
    step(1'b1, 1'b1, mk(1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 32'hC0C0C0C0), acc);
    chk("bp_ready_low", in_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, mk(1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 32'hC0C0C0C0), acc);
      if (acc) break;
    end
    idle(3);
    chk_rf();

    // Saturation: 300 conflicting bundles.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, mk(1'b1, 3'(i), $urandom, 1'b1, 3'(i), $urandom), acc);
    end
    idle(2);
    chk("sat_cnt", conflict_cnt, 8'd255);
    chk_rf();

    // Asynchronous reset mid-cycle with head and skid both full.
    step(1'b1, 1'b1, mk(1'b1, 3'd6, 32'h66666666, 1'b1, 3'd7, 32'h77777777), acc);
    step(1'b1, 1'b1, mk(1'b1, 3'd6, 32'h16161616, 1'b0, 3'd0, 32'h0), acc);
    step(1'b0, 1'b1, '0, acc);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_rw1", regWrite1, 1'b0);
    chk("mid_rst_rw2", regWrite2, 1'b0);
    chk("mid_rst_dec", dec_out, 8'h00);
    chk("mid_rst_wd1", writeData_1, 32'h0);
    chk("mid_rst_cnt", conflict_cnt, 8'd0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    wb_hold = 1'b0;
    in_valid = 1'b0;
    chk_rf();

    // Random traffic; an offered bundle stays on the bus until accepted.
    have_pend = 1'b0;
    pend = '0;
    for (int i = 0; i < 600; i++) begin
      if (!have_pend && ($urandom_range(3) != 0)) begin
        pend = rnd_bundle();
        have_pend = 1'b1;
      end
      step(have_pend, ($urandom_range(3) == 0), pend, acc);
      if (acc) have_pend = 1'b0;
    end
    idle(4);
    chk_rf();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
- Two-slot VLIW write-back commit stage, directly upstream of the register file built from 2-write-port 32-bit registers.
- Latches the two slot results of each bundle (enable, destination, data) behind a valid/ready handshake with a one-entry skid buffer.
- Drives, per cycle, the shared writeData_1/writeData_2 and regWrite1/regWrite2 buses, plus one decode bit and one write-data select bit per register.
- Resolves same-destination conflicts in favour of slot 2 and counts them.

Parameters:
- NREG, 8, number of architectural registers; must equal 2**AW.
- AW, 3, destination register index width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state in this block updates on posedge; the register file samples on negedge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  bundle present from the execute stage.
- in_ready  out  1  stage can accept a bundle this cycle.
- s1_we  in  1  slot 1 write enable.
- s1_rd  in  AW  slot 1 destination.
- s1_data  in  DW  slot 1 result.
- s2_we  in  1  slot 2 write enable.
- s2_rd  in  AW  slot 2 destination.
- s2_data  in  DW  slot 2 result.
- wb_hold  in  1  register file not writable this cycle; the head bundle stays.
- regWrite1  out  1  slot 1 write strobe to the register file.
- regWrite2  out  1  slot 2 write strobe.
- writeData_1  out  DW  slot 1 data bus.
- writeData_2  out  DW  slot 2 data bus.
- dec_out  out  NREG  per-register decode bit; drives decOut1b of register i.
- wsel  out  NREG  per-register writeData_sel; 1 selects slot 2.
- conflict_cnt  out  8  saturating count of committed same-destination bundles.

Behaviour:
- State:
  - head entry: head_v plus payload we1, rd1, d1, we2, rd2, d2.
  - skid entry: skid_v plus the same payload.
  - conflict_cnt.
- Reset (asynchronous): head_v=0, skid_v=0, conflict_cnt=0, all payload fields 0.
  - Consequently regWrite1=0, regWrite2=0, dec_out=0, wsel=0, writeData buses 0, in_ready=1.
  - Reset mid-operation drops any buffered bundle with no partial write.
- Handshake:
  - in_ready = ~skid_v, derived from a register only (no combinational path from wb_hold).
  - accept = in_valid & in_ready.
  - drain = head_v & ~wb_hold.
- Posedge update when drain | ~head_v:
  - If skid_v: head <= skid, skid_v <= 0; an accepted input goes to skid.
  - Else if accept: head <= input.
  - Else: head_v <= 0.
- Posedge update when head_v & wb_hold: if accept, skid <= input and skid_v <= 1.
- No bundle is lost or duplicated. Bundle order is preserved.
- Latency: an accepted bundle on an empty stage drives the register file in the next cycle; its write lands at the following negedge.
- Outputs are combinational from head and gated by g = head_v & ~wb_hold:
  - regWrite1 = g & we1
  - regWrite2 = g & we2
  - writeData_1 = d1
  - writeData_2 = d2
  - dec_out = (we1 ? onehot(rd1) : 0) | (we2 ? onehot(rd2) : 0), then ANDed with g
  - wsel = we2 ? onehot(rd2) : 0, NOT gated by g
- Conflict: we1 & we2 & rd1==rd2.
  - dec_out has a single bit set and wsel selects slot 2, so slot 2 wins and slot 1 is dropped for that register.
  - On drain of such a bundle, conflict_cnt increments, saturating at 255.
- A bundle with we1=we2=0 still occupies the head for one drain cycle and writes nothing.
- Every write strobe is asserted in exactly one cycle per bundle, the drain cycle. During wb_hold all strobes are 0.

Decomposition:
- Shared header:
  - NREG, AW, DW constants.
  - Bundle field layout: {we2, rd2, d2, we1, rd1, d1} packed width 2*(1+AW+DW).
- One sub-module, wb_rd_decoder: AW-to-NREG one-hot decoder with enable, instantiated twice.
- The pipeline state is built from the existing generic register cells where the width fits. Skid and head control stay in this block.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with a bundle in head and in skid -> immediately all strobes 0, dec_out=0, in_ready=1, conflict_cnt=0; no register changes.
- Dual write: s1(we,rd=2,0x11111111), s2(we,rd=5,0x22222222), wb_hold=0 -> next cycle regWrite1=regWrite2=1, dec_out=0x24, wsel=0x20; after the negedge R2=0x11111111 and R5=0x22222222.
- Conflict: s1(rd=3,0xAAAA0000) and s2(rd=3,0x0000BBBB), both we -> dec_out=0x08, wsel=0x08; R3=0x0000BBBB; conflict_cnt goes 0->1.
- Backpressure: hold wb_hold=1 for 3 cycles while offering bundles A, B, C every cycle -> A stays in head, B goes to skid, in_ready=0, C not accepted. Release wb_hold -> commit order A, B, C with each write exactly once.
- Saturation: 300 conflicting bundles -> conflict_cnt stops at 255.
- Idle bundle: we1=we2=0 -> one drain cycle with all strobes 0 and dec_out=0; the register file is unchanged.
